mfp_ahb_botseq: RTL

MFP_AHB_BOTSEQ -- requirements
Module: mfp_ahb_botseq

---
 rtl/mfp_ahb_botseq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mfp_ahb_botseq.sv
// Bot command sequencer: a command FIFO of {ticks, motor} words played out on bot_ctrl,
// one tick per bot update edge. Define MFP_BOTSEQ_WATCHDOG_EN to build the RUN watchdog.
module mfp_ahb_botseq #(
  parameter int DEPTH      = 8,
  parameter int WDT_CYCLES = 50000000
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     cmd_we,
  input  logic [15:0]              cmd_wdata,
  input  logic                     flush,
  input  logic                     bot_upd,
  output logic [7:0]               bot_ctrl,
  output logic                     int_ack,
  output logic                     cmd_full,
  output logic                     cmd_empty,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf,
  output logic                     wdt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || WDT_CYCLES < 1) begin : g_bad_cfg
    $error("mfp_ahb_botseq: unsupported DEPTH/WDT_CYCLES");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    tick;
  logic [15:0]   head;
  logic          upd_edge, wr, pop, fin, abort, wdt_trip;

  // int_ack doubles as the previous-cycle copy of bot_upd for edge detection
  assign upd_edge  = bot_upd & ~int_ack;
  assign head      = mem[rd_ptr];
  assign cmd_full  = (cmd_count == FULL_CNT);
  assign cmd_empty = (cmd_count == '0);
  assign busy      = (state == RUN);
  assign abort     = flush | wdt_trip;
  assign wr        = cmd_we & ~cmd_full & ~abort;

  // A command slot frees up in IDLE, while skipping 0-tick entries (tick == 0 in RUN),
  // or when the last tick of the current command is consumed.
  logic slot_free;
  assign slot_free = (state == IDLE) || (tick == 8'd0) || (upd_edge && tick == 8'd1);
  assign pop       = !abort && !cmd_empty && slot_free;
  assign fin       = !abort && busy && cmd_empty && slot_free;

`ifdef MFP_BOTSEQ_WATCHDOG_EN
  logic [31:0] wdt_cnt;

  assign wdt_trip = busy && !upd_edge && (wdt_cnt == 32'(WDT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wdt_cnt <= '0;
      wdt_err <= 1'b0;
    end else begin
      if (!busy || upd_edge || wdt_trip) wdt_cnt <= '0;
      else                               wdt_cnt <= wdt_cnt + 32'd1;
      if (flush)         wdt_err <= 1'b0;
      else if (wdt_trip) wdt_err <= 1'b1;
    end
  end
`else
  assign wdt_trip = 1'b0;
  assign wdt_err  = 1'b0;
`endif

  // Storage is not reset; it is only read when cmd_count is nonzero
  always_ff @(posedge HCLK) begin
    if (wr) mem[wr_ptr] <= cmd_wdata;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      bot_ctrl  <= '0;
      tick      <= '0;
      int_ack   <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
    end else begin
      int_ack <= bot_upd;
      done    <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        bot_ctrl  <= '0;
        tick      <= '0;
        ovf       <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cmd_count <= '0;
      end else begin
        if (cmd_we && cmd_full) ovf <= 1'b1;
        if (wr)  wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          tick   <= head[15:8];
          if (head[15:8] != 8'd0) begin
            bot_ctrl <= head[7:0];
            state    <= RUN;
          end
        end else if (fin) begin
          bot_ctrl <= '0;
          tick     <= '0;
          state    <= IDLE;
          done     <= 1'b1;
        end else if (busy && upd_edge && tick > 8'd1) begin
          tick <= tick - 8'd1;
        end
        case ({wr, pop})
          2'b10:   cmd_count <= cmd_count + 1'b1;
          2'b01:   cmd_count <= cmd_count - 1'b1;
          default: cmd_count <= cmd_count;
        endcase
      end
    end
  end

endmodule
